// File: rtl/ram_loader.sv
// Serial-host loader: turns UART command bytes into BRAM port-B writes/reads,
// returns read data and write checksums, and controls the 6809 reset hold.
module ram_loader #(
  parameter int unsigned ADDR       = 15,
  parameter int unsigned DATA       = 8,
  parameter int unsigned TIMEOUT    = 1000000,
  parameter bit          HOLD_RESET = 1'b1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [7:0]      rx_data,
  input  logic            rx_valid,
  output logic [7:0]      tx_data,
  output logic            tx_valid,
  input  logic            tx_ready,
  output logic            b_en,
  output logic            b_wr,
  output logic [ADDR-1:0] b_addr,
  output logic [DATA-1:0] b_din,
  input  logic [DATA-1:0] b_dout,
  output logic            cpu_hold,
  output logic            busy
);

  localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    IDLE, AHI, ALO, LEN, WDATA, RREQ, RWAIT, RSEND, REPLY
  } state_t;

  state_t          state_q, state_d;
  logic            cmd_wr_q, cmd_wr_d;
  logic [7:0]      addr_hi_q, addr_hi_d;
  logic [ADDR-1:0] addr_q, addr_d;
  logic [8:0]      count_q, count_d;
  logic [7:0]      csum_q, csum_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            hold_q, hold_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_valid_q, tx_valid_d;
  logic            b_en_q, b_en_d;
  logic            b_wr_q, b_wr_d;
  logic [ADDR-1:0] b_addr_q, b_addr_d;
  logic [DATA-1:0] b_din_q, b_din_d;
  logic            expired;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cmd_wr_q   <= 1'b0;
      addr_hi_q  <= '0;
      addr_q     <= '0;
      count_q    <= '0;
      csum_q     <= '0;
      timer_q    <= '0;
      hold_q     <= HOLD_RESET;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      b_en_q     <= 1'b0;
      b_wr_q     <= 1'b0;
      b_addr_q   <= '0;
      b_din_q    <= '0;
    end else begin
      state_q    <= state_d;
      cmd_wr_q   <= cmd_wr_d;
      addr_hi_q  <= addr_hi_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      csum_q     <= csum_d;
      timer_q    <= timer_d;
      hold_q     <= hold_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      b_en_q     <= b_en_d;
      b_wr_q     <= b_wr_d;
      b_addr_q   <= b_addr_d;
      b_din_q    <= b_din_d;
    end
  end

  // Expiry only matters when no byte arrives this cycle: the byte wins.
  assign expired = (timer_q == '0) && !rx_valid;

  always_comb begin
    state_d    = state_q;
    cmd_wr_d   = cmd_wr_q;
    addr_hi_d  = addr_hi_q;
    addr_d     = addr_q;
    count_d    = count_q;
    csum_d     = csum_q;
    hold_d     = hold_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    b_en_d     = 1'b0;
    b_wr_d     = 1'b0;
    b_addr_d   = b_addr_q;
    b_din_d    = b_din_q;

    if (rx_valid || (tx_valid_q && tx_ready)) begin
      timer_d = TW'(TIMEOUT - 1);
    end else if (timer_q != '0) begin
      timer_d = timer_q - 1'b1;
    end else begin
      timer_d = timer_q;
    end

    case (state_q)
      IDLE: begin
        if (rx_valid) begin
          case (rx_data)
            8'h57: begin
              cmd_wr_d = 1'b1;
              csum_d   = '0;
              state_d  = AHI;
            end
            8'h52: begin
              cmd_wr_d = 1'b0;
              state_d  = AHI;
            end
            8'h48: begin
              hold_d     = 1'b1;
              tx_data_d  = 8'h06;
              tx_valid_d = 1'b1;
              state_d    = REPLY;
            end
            8'h47: begin
              hold_d     = 1'b0;
              tx_data_d  = 8'h06;
              tx_valid_d = 1'b1;
              state_d    = REPLY;
            end
            default: begin
              tx_data_d  = 8'h15;
              tx_valid_d = 1'b1;
              state_d    = REPLY;
            end
          endcase
        end
      end
      AHI: begin
        if (rx_valid) begin
          addr_hi_d = rx_data;
          state_d   = ALO;
        end else if (expired) begin
          state_d = IDLE;
        end
      end
      ALO: begin
        if (rx_valid) begin
          addr_d  = ADDR'({addr_hi_q, rx_data});
          state_d = LEN;
        end else if (expired) begin
          state_d = IDLE;
        end
      end
      LEN: begin
        if (rx_valid) begin
          count_d = (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
          if (cmd_wr_q) begin
            state_d = WDATA;
          end else begin
            b_en_d   = 1'b1;
            b_addr_d = addr_q;
            state_d  = RREQ;
          end
        end else if (expired) begin
          state_d = IDLE;
        end
      end
      WDATA: begin
        if (rx_valid) begin
          b_en_d   = 1'b1;
          b_wr_d   = 1'b1;
          b_addr_d = addr_q;
          b_din_d  = rx_data;
          addr_d   = addr_q + 1'b1;
          csum_d   = csum_q + rx_data;
          count_d  = count_q - 9'd1;
          if (count_q == 9'd1) begin
            tx_data_d  = csum_q + rx_data;
            tx_valid_d = 1'b1;
            state_d    = REPLY;
          end
        end else if (expired) begin
          state_d = IDLE;
        end
      end
      // b_en is raised on entry to RREQ so the registered BRAM output is ready in RWAIT.
      RREQ: state_d = RWAIT;
      RWAIT: begin
        tx_data_d  = b_dout;
        tx_valid_d = 1'b1;
        state_d    = RSEND;
      end
      RSEND: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          addr_d     = addr_q + 1'b1;
          count_d    = count_q - 9'd1;
          if (count_q == 9'd1) begin
            state_d = IDLE;
          end else begin
            b_en_d   = 1'b1;
            b_addr_d = addr_q + 1'b1;
            state_d  = RREQ;
          end
        end
      end
      REPLY: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign b_en     = b_en_q;
  assign b_wr     = b_wr_q;
  assign b_addr   = b_addr_q;
  assign b_din    = b_din_q;
  assign cpu_hold = hold_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_ram_loader.sv
// Directed bench for ram_loader: write/read commands, wrap, len=0, control,
// timeout and asynchronous reset, against a behavioural BRAM model.
module tb_ram_loader;

  localparam int unsigned ADDR = 15;
  localparam int unsigned TO   = 50;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [7:0]      rx_data = '0;
  logic            rx_valid = 1'b0;
  logic            tx_ready = 1'b0;
  logic [7:0]      tx_data;
  logic            tx_valid;
  logic            b_en;
  logic            b_wr;
  logic [ADDR-1:0] b_addr;
  logic [7:0]      b_din;
  logic [7:0]      b_dout = '0;
  logic            cpu_hold;
  logic            busy;

  int checks = 0;
  int failures = 0;

  logic [7:0]      mem [0:(1<<ADDR)-1];
  logic [ADDR-1:0] wq_addr [$];
  logic [7:0]      wq_data [$];
  int              wr_cycles = 0;

  ram_loader #(.ADDR(ADDR), .DATA(8), .TIMEOUT(TO), .HOLD_RESET(1'b1)) dut (
    .clk(clk), .reset_n(reset_n),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .b_en(b_en), .b_wr(b_wr), .b_addr(b_addr), .b_din(b_din), .b_dout(b_dout),
    .cpu_hold(cpu_hold), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural BRAM port B with registered read, plus a write log.
  always @(posedge clk) begin
    if (b_en) begin
      if (b_wr) mem[b_addr] <= b_din;
      b_dout <= mem[b_addr];
    end
    if (b_en && b_wr) begin
      wq_addr.push_back(b_addr);
      wq_data.push_back(b_din);
      wr_cycles++;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic get_tx(input int stall, output logic [7:0] d, output bit got, output bit stable);
    got = 1'b0;
    stable = 1'b1;
    d = '0;
    for (int i = 0; i < 200; i++) begin
      if (tx_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (got) begin
      d = tx_data;
      repeat (stall) begin
        @(negedge clk);
        if (tx_valid !== 1'b1 || tx_data !== d) stable = 1'b0;
      end
      tx_ready = 1'b1;
      @(negedge clk);
      tx_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_tx: tx_valid=%b tx_data=%h expected 0/00", tx_valid, tx_data);
    end
    checks++;
    if (b_en !== 1'b0 || b_wr !== 1'b0 || b_addr !== '0 || b_din !== 8'h00) begin
      failures++;
      $display("FAIL reset_port: b_en=%b b_wr=%b b_addr=%h b_din=%h expected all 0", b_en, b_wr, b_addr, b_din);
    end
    checks++;
    if (cpu_hold !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: cpu_hold=%b busy=%b expected 1/0", cpu_hold, busy);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || tx_valid !== 1'b0 || b_en !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset: busy=%b tx_valid=%b b_en=%b expected 0", busy, tx_valid, b_en);
    end
  endtask

  task automatic test_write();
    logic [7:0] d;
    bit got, st;
    logic [7:0] dat [3];
    dat[0] = 8'hAA; dat[1] = 8'hBB; dat[2] = 8'hCC;
    wq_addr.delete(); wq_data.delete();
    send_byte(8'h57); send_byte(8'h01); send_byte(8'h00); send_byte(8'h03);
    for (int i = 0; i < 3; i++) begin
      send_byte(dat[i]);
      checks++;
      if (b_en !== 1'b1 || b_wr !== 1'b1 || b_addr !== ADDR'(16'h0100 + i) || b_din !== dat[i]) begin
        failures++;
        $display("FAIL write_strobe%0d: en=%b wr=%b addr=%h din=%h expected 1/1/%h/%h",
                 i, b_en, b_wr, b_addr, b_din, 16'h0100 + i, dat[i]);
      end
      @(negedge clk);
      checks++;
      if (b_en !== 1'b0) begin
        failures++;
        $display("FAIL write_single%0d: b_en=%b expected 0", i, b_en);
      end
    end
    get_tx(0, d, got, st);
    checks++;
    if (!got || d !== 8'h31) begin
      failures++;
      $display("FAIL write_csum: got=%0d data=%h expected 1/31", got, d);
    end
    checks++;
    if (busy !== 1'b0 || tx_valid !== 1'b0) begin
      failures++;
      $display("FAIL write_done: busy=%b tx_valid=%b expected 0/0", busy, tx_valid);
    end
    checks++;
    if (wq_addr.size() != 3) begin
      failures++;
      $display("FAIL write_count: writes=%0d expected 3", wq_addr.size());
    end
  endtask

  task automatic test_read_backpressure();
    logic [7:0] d;
    bit got, st;
    int wrb;
    logic [7:0] exp [3];
    exp[0] = 8'hAA; exp[1] = 8'hBB; exp[2] = 8'hCC;
    wrb = wr_cycles;
    send_byte(8'h52); send_byte(8'h01); send_byte(8'h00); send_byte(8'h03);
    for (int i = 0; i < 3; i++) begin
      get_tx(5, d, got, st);
      checks++;
      if (!got || d !== exp[i] || !st) begin
        failures++;
        $display("FAIL read_byte%0d: got=%0d data=%h stable=%0d expected 1/%h/1", i, got, d, st, exp[i]);
      end
    end
    checks++;
    if (wr_cycles != wrb) begin
      failures++;
      $display("FAIL read_nowrite: write cycles=%0d expected 0", wr_cycles - wrb);
    end
    checks++;
    if (busy !== 1'b0 || tx_valid !== 1'b0) begin
      failures++;
      $display("FAIL read_done: busy=%b tx_valid=%b expected 0/0", busy, tx_valid);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] d;
    bit got, st;
    wq_addr.delete(); wq_data.delete();
    send_byte(8'h57); send_byte(8'h7F); send_byte(8'hFF); send_byte(8'h02);
    send_byte(8'h11); send_byte(8'h22);
    get_tx(0, d, got, st);
    checks++;
    if (!got || d !== 8'h33) begin
      failures++;
      $display("FAIL wrap_csum: got=%0d data=%h expected 1/33", got, d);
    end
    checks++;
    if (wq_addr.size() != 2 || wq_addr[0] !== 15'h7FFF || wq_data[0] !== 8'h11 ||
        wq_addr[1] !== 15'h0000 || wq_data[1] !== 8'h22) begin
      failures++;
      $display("FAIL wrap_writes: n=%0d a0=%h d0=%h a1=%h d1=%h expected 2/7fff/11/0000/22",
               wq_addr.size(), wq_addr[0], wq_data[0], wq_addr[1], wq_data[1]);
    end
  endtask

  task automatic test_len0();
    logic [7:0] d;
    bit got, st;
    wq_addr.delete(); wq_data.delete();
    send_byte(8'h57); send_byte(8'h02); send_byte(8'h00); send_byte(8'h00);
    for (int i = 0; i < 256; i++) begin
      send_byte(8'(i));
      if (i == 254) begin
        checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b1) begin
          failures++;
          $display("FAIL len0_early: tx_valid=%b busy=%b after 255 bytes expected 0/1", tx_valid, busy);
        end
      end
    end
    get_tx(0, d, got, st);
    checks++;
    if (!got || d !== 8'h80) begin
      failures++;
      $display("FAIL len0_csum: got=%0d data=%h expected 1/80", got, d);
    end
    checks++;
    if (wq_addr.size() != 256 || wq_addr[0] !== 15'h0200 || wq_addr[255] !== 15'h02FF || wq_data[255] !== 8'hFF) begin
      failures++;
      $display("FAIL len0_writes: n=%0d first=%h last=%h lastd=%h expected 256/0200/02ff/ff",
               wq_addr.size(), wq_addr[0], wq_addr[255], wq_data[255]);
    end
  endtask

  task automatic test_control();
    logic [7:0] d;
    bit got, st;
    send_byte(8'h47);
    get_tx(1, d, got, st);
    checks++;
    if (!got || d !== 8'h06 || cpu_hold !== 1'b0) begin
      failures++;
      $display("FAIL ctrl_go: got=%0d data=%h hold=%b expected 1/06/0", got, d, cpu_hold);
    end
    send_byte(8'h48);
    get_tx(0, d, got, st);
    checks++;
    if (!got || d !== 8'h06 || cpu_hold !== 1'b1) begin
      failures++;
      $display("FAIL ctrl_hold: got=%0d data=%h hold=%b expected 1/06/1", got, d, cpu_hold);
    end
    send_byte(8'h5A);
    get_tx(0, d, got, st);
    checks++;
    if (!got || d !== 8'h15 || cpu_hold !== 1'b1) begin
      failures++;
      $display("FAIL ctrl_nak: got=%0d data=%h hold=%b expected 1/15/1", got, d, cpu_hold);
    end
  endtask

  task automatic test_timeout();
    logic [7:0] d;
    bit got, st;
    bit saw_tx;
    logic busy_before, busy_after;
    saw_tx = 1'b0;
    busy_before = 1'b0;
    busy_after = 1'b1;
    wq_addr.delete(); wq_data.delete();
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h10);
    for (int k = 1; k <= int'(TO) + 5; k++) begin
      @(negedge clk);
      if (tx_valid === 1'b1) saw_tx = 1'b1;
      if (k == int'(TO) - 1) busy_before = busy;
      if (k == int'(TO)) busy_after = busy;
    end
    checks++;
    if (busy_before !== 1'b1 || busy_after !== 1'b0) begin
      failures++;
      $display("FAIL timeout_edge: busy@%0d=%b busy@%0d=%b expected 1/0", TO - 1, busy_before, TO, busy_after);
    end
    checks++;
    if (saw_tx || wq_addr.size() != 0) begin
      failures++;
      $display("FAIL timeout_quiet: tx_seen=%0d writes=%0d expected 0/0", saw_tx, wq_addr.size());
    end
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
    get_tx(0, d, got, st);
    checks++;
    if (!got || d !== 8'h22 || busy !== 1'b0) begin
      failures++;
      $display("FAIL timeout_recover: got=%0d data=%h busy=%b expected 1/22/0", got, d, busy);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    bit got, st;
    bit seen;
    send_byte(8'h47);
    get_tx(0, d, got, st);
    send_byte(8'h52); send_byte(8'h01); send_byte(8'h00); send_byte(8'h01);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (tx_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!seen || cpu_hold !== 1'b0) begin
      failures++;
      $display("FAIL rsend_reach: tx_valid_seen=%0d hold=%b expected 1/0", seen, cpu_hold);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h00 || busy !== 1'b0 || cpu_hold !== 1'b1 || b_en !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: tx_valid=%b tx_data=%h busy=%b hold=%b b_en=%b expected 0/00/0/1/0",
               tx_valid, tx_data, busy, cpu_hold, b_en);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (tx_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_after: tx_valid=%b busy=%b expected 0/0", tx_valid, busy);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_backpressure();
    test_wrap();
    test_len0();
    test_control();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
